// File: rtl/memory_unit_param.sv
`timescale 1ns/1ps
// memory_unit_param: DEPTH x DATA_W word store behind one command port.
// An FSM sequences read, write and bulk-clear commands and publishes its
// state on the state output.
//
// Handshake: a command is taken on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE and outside reset.
// The master must hold req_cmd/req_addr/req_wdata stable while req_valid is
// high. Inputs are ignored at all other times. done pulses once per accepted
// command. rsp_valid pulses once per read completion.
module memory_unit_param #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int DEPTH  = 2 ** ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic [1:0]        req_cmd,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              done,
   output logic              err,
   output logic [1:0]        state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_WRITE = 2'b01,
      ST_READ  = 2'b10,
      ST_CLEAR = 2'b11
   } state_t;

   localparam logic [1:0] CMD_READ  = 2'b00;
   localparam logic [1:0] CMD_WRITE = 2'b01;
   localparam logic [1:0] CMD_CLEAR = 2'b10;

   // DEPTH can equal 2**ADDR_W, so the range compare needs one extra bit.
   localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

   state_t              state_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [ADDR_W-1:0]   cnt_q;
   logic                rsp_valid_q;
   logic [DATA_W-1:0]   rsp_data_q;
   logic                done_q;
   logic                err_q;
   logic                nop_q;

   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                accept;
   logic                addr_ok;
   logic [DATA_W-1:0]   rd_word;
   logic                mem_we_d;
   logic [ADDR_W-1:0]   mem_waddr_d;
   logic [DATA_W-1:0]   mem_wdata_d;

   assign req_ready = (state_q == ST_IDLE) && !rst;
   assign accept    = req_valid && req_ready;
   assign addr_ok   = ({1'b0, addr_q} < DEPTH_W);

   // Out-of-range reads return zero rather than touching the array.
   assign rd_word   = addr_ok ? mem_q[addr_q] : '0;

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign done      = done_q;
   assign err       = err_q;
   assign state     = state_q;

   // Select the single memory write performed on the next edge, if any.
   always_comb begin
      mem_we_d    = 1'b0;
      mem_waddr_d = addr_q;
      mem_wdata_d = wdata_q;
      if (state_q == ST_WRITE && addr_ok) begin
         mem_we_d = 1'b1;
      end else if (state_q == ST_CLEAR) begin
         mem_we_d    = 1'b1;
         mem_waddr_d = cnt_q;
         mem_wdata_d = '0;
      end
   end

   // Storage array; not reset, but reset blocks any pending write or clear.
   always_ff @(posedge clk) begin
      if (!rst && mem_we_d) begin
         mem_q[mem_waddr_d] <= mem_wdata_d;
      end
   end

   // Command FSM with registered response pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         nop_q       <= 1'b0;
      end else begin
         // A NOP accepted last edge completes on this edge.
         rsp_valid_q <= 1'b0;
         done_q      <= nop_q;
         err_q       <= 1'b0;
         nop_q       <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  case (req_cmd)
                     CMD_READ:  state_q <= ST_READ;
                     CMD_WRITE: state_q <= ST_WRITE;
                     CMD_CLEAR: begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                     end
                     default:   nop_q <= 1'b1;
                  endcase
               end
            end
            ST_WRITE: begin
               done_q  <= 1'b1;
               err_q   <= !addr_ok;
               state_q <= ST_IDLE;
            end
            ST_READ: begin
               rsp_data_q  <= rd_word;
               rsp_valid_q <= 1'b1;
               done_q      <= 1'b1;
               err_q       <= !addr_ok;
               state_q     <= ST_IDLE;
            end
            ST_CLEAR: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q   <= '0;
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
